// File: rtl/servo_out_guard.sv
// Output-safing stage behind the servo watchdog. It gates the servo PWM and
// direction outputs, sequences a timed shutdown on a trip, and keeps a sticky fault.
module servo_out_guard #(
    parameter int unsigned N    = 4,
    parameter int unsigned DEAD = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wdt_trip,
    input  logic         arm,
    input  logic         clear,
    input  logic [N-1:0] pwm_in,
    input  logic [N-1:0] dir_in,
    output logic [N-1:0] pwm_out,
    output logic [N-1:0] dir_out,
    output logic         fault,
    output logic         running,
    output logic [7:0]   trip_count
);

    localparam logic [7:0] DeadInit = 8'(DEAD);

    typedef enum logic [2:0] {
        StSafe,
        StArming,
        StRun,
        StHold,
        StTripped
    } state_e;

    state_e       state_q, state_d;
    logic [N-1:0] release_q, release_d;
    logic [N-1:0] rel_upd;
    logic [7:0]   dead_q, dead_d;
    logic [7:0]   trip_count_q, trip_count_d;
    logic [N-1:0] pwm_out_q, pwm_out_d;
    logic [N-1:0] dir_out_q, dir_out_d;
    logic         fault_q, fault_d;
    logic         running_q, running_d;

    always_comb begin
        state_d      = state_q;
        release_d    = release_q;
        dead_d       = dead_q;
        trip_count_d = trip_count_q;
        pwm_out_d    = '0;
        dir_out_d    = '0;
        // A channel is released once it has been seen low, so no runt pulse escapes.
        rel_upd      = release_q | ~pwm_in;

        unique case (state_q)
            StSafe: begin
                if (arm && !wdt_trip) state_d = StArming;
            end
            StArming: begin
                if (wdt_trip) state_d = StHold;
                else if (&rel_upd) state_d = StRun;
            end
            StRun: begin
                if (wdt_trip) state_d = StHold;
            end
            StHold: begin
                dead_d = dead_q - 8'd1;
                if (dead_q <= 8'd1) state_d = StTripped;
            end
            StTripped: begin
                if (clear && !wdt_trip) state_d = StSafe;
            end
            default: state_d = StSafe;
        endcase

        if (state_d == StHold && state_q != StHold) begin
            dead_d = DeadInit;
            if (trip_count_q != 8'hff) trip_count_d = trip_count_q + 8'd1;
        end

        if (state_d == StSafe || state_d == StHold || state_d == StTripped) begin
            release_d = '0;
        end else if (state_q == StArming) begin
            release_d = rel_upd;
        end

        // Outputs are registered and reflect the state being entered.
        case (state_d)
            StArming: begin
                pwm_out_d = release_d & pwm_in;
                dir_out_d = dir_in;
            end
            StRun: begin
                pwm_out_d = pwm_in;
                dir_out_d = dir_in;
            end
            StHold: begin
                dir_out_d = dir_out_q;
            end
            default: begin
                pwm_out_d = '0;
                dir_out_d = '0;
            end
        endcase

        fault_d   = (state_d == StHold) || (state_d == StTripped);
        running_d = (state_d == StRun);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StSafe;
            release_q    <= '0;
            dead_q       <= '0;
            trip_count_q <= '0;
            pwm_out_q    <= '0;
            dir_out_q    <= '0;
            fault_q      <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            release_q    <= release_d;
            dead_q       <= dead_d;
            trip_count_q <= trip_count_d;
            pwm_out_q    <= pwm_out_d;
            dir_out_q    <= dir_out_d;
            fault_q      <= fault_d;
            running_q    <= running_d;
        end
    end

    assign pwm_out    = pwm_out_q;
    assign dir_out    = dir_out_q;
    assign fault      = fault_q;
    assign running    = running_q;
    assign trip_count = trip_count_q;

endmodule

// File: tb/tb_servo_out_guard.sv
// Bench for servo_out_guard: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model.
module tb_servo_out_guard;

    localparam int DEAD = 8;
    localparam int M_SAFE = 0, M_ARM = 1, M_RUN = 2, M_HOLD = 3, M_TRIP = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wdt_trip = 1'b0, arm = 1'b0, clear = 1'b0;
    logic [3:0] pwm_in = '0, dir_in = '0;
    logic [3:0] pwm_out, dir_out;
    logic       fault, running;
    logic [7:0] trip_count;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    int         m_mode;
    int         m_dead;
    int         m_cnt;
    logic [3:0] m_seen_low;
    logic [3:0] m_pwm, m_dir;
    logic       m_fault, m_run;

    servo_out_guard #(.N(4), .DEAD(DEAD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wdt_trip   (wdt_trip),
        .arm        (arm),
        .clear      (clear),
        .pwm_in     (pwm_in),
        .dir_in     (dir_in),
        .pwm_out    (pwm_out),
        .dir_out    (dir_out),
        .fault      (fault),
        .running    (running),
        .trip_count (trip_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = M_SAFE; m_dead = 0; m_cnt = 0; m_seen_low = '0;
        m_pwm = '0; m_dir = '0; m_fault = 1'b0; m_run = 1'b0;
    endtask

    // One clock of the specified behaviour, evaluated on the inputs about to be sampled.
    task automatic model_step();
        int         nxt;
        logic [3:0] seen;
        nxt  = m_mode;
        seen = (m_mode == M_ARM) ? (m_seen_low | ~pwm_in) : m_seen_low;
        case (m_mode)
            M_SAFE: if (arm && !wdt_trip) nxt = M_ARM;
            M_ARM:  if (wdt_trip) nxt = M_HOLD; else if (seen == 4'hf) nxt = M_RUN;
            M_RUN:  if (wdt_trip) nxt = M_HOLD;
            M_HOLD: begin m_dead = m_dead - 1; if (m_dead == 0) nxt = M_TRIP; end
            default: if (clear && !wdt_trip) nxt = M_SAFE;
        endcase
        if (nxt == M_HOLD && m_mode != M_HOLD) begin
            m_dead = DEAD;
            m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
        m_seen_low = (nxt == M_ARM || nxt == M_RUN) ? seen : 4'h0;
        case (nxt)
            M_ARM:  begin m_pwm = m_seen_low & pwm_in; m_dir = dir_in; end
            M_RUN:  begin m_pwm = pwm_in; m_dir = dir_in; end
            M_HOLD: m_pwm = '0;
            default: begin m_pwm = '0; m_dir = '0; end
        endcase
        m_fault = (nxt == M_HOLD || nxt == M_TRIP);
        m_run   = (nxt == M_RUN);
        m_mode  = nxt;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; wdt_trip = 0; arm = 0; clear = 0; pwm_in = '0; dir_in = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({pwm_out, dir_out, fault, running, trip_count} !== 18'h0) begin
            n_err++;
            $display("FAIL reset: got pwm=%b dir=%b fault=%b run=%b cnt=%0d, want all 0",
                     pwm_out, dir_out, fault, running, trip_count);
        end
    endtask

    task automatic test_arm_zero();
        logic [3:0] v;
        arm = 1; pwm_in = 4'b0000; tick();
        arm = 0;
        n_vec++;
        if (running !== 1'b0) begin
            n_err++; $display("FAIL arming_cycle: running=%b want 0", running);
        end
        tick();
        n_vec++;
        if (running !== 1'b1) begin
            n_err++; $display("FAIL arm_to_run: running=%b want 1", running);
        end
        for (int i = 0; i < 5; i++) begin
            v = 4'($urandom);
            pwm_in = v; dir_in = ~v; tick();
            n_vec++;
            if (pwm_out !== v || dir_out !== ~v) begin
                n_err++;
                $display("FAIL passthru: pwm=%b dir=%b want pwm=%b dir=%b", pwm_out, dir_out, v, ~v);
            end
        end
    endtask

    task automatic test_runt();
        do_reset();
        pwm_in = 4'b0101; arm = 1; tick();
        arm = 0; tick();
        n_vec++;
        if (pwm_out !== 4'b0000 || running !== 1'b0) begin
            n_err++; $display("FAIL runt_hold: pwm=%b run=%b want 0000/0", pwm_out, running);
        end
        pwm_in = 4'b0100; tick();
        pwm_in = 4'b0101; tick();
        n_vec++;
        if (pwm_out !== 4'b0001 || running !== 1'b0) begin
            n_err++; $display("FAIL runt_bit0: pwm=%b run=%b want 0001/0", pwm_out, running);
        end
        pwm_in = 4'b0001; tick();
        n_vec++;
        if (pwm_out !== 4'b0001 || running !== 1'b1) begin
            n_err++; $display("FAIL runt_run: pwm=%b run=%b want 0001/1", pwm_out, running);
        end
    endtask

    task automatic test_trip();
        pwm_in = 4'b1111; dir_in = 4'b1010; tick();
        wdt_trip = 1; tick();
        wdt_trip = 0; dir_in = 4'b0101;
        n_vec++;
        if (pwm_out !== 4'b0000 || dir_out !== 4'b1010 || fault !== 1'b1 || trip_count !== 8'd1)
        begin
            n_err++;
            $display("FAIL trip_entry: pwm=%b dir=%b fault=%b cnt=%0d want 0000/1010/1/1",
                     pwm_out, dir_out, fault, trip_count);
        end
        for (int i = 1; i < DEAD; i++) begin
            tick();
            n_vec++;
            if (dir_out !== 4'b1010 || pwm_out !== 4'b0000 || fault !== 1'b1) begin
                n_err++;
                $display("FAIL dead_hold[%0d]: dir=%b pwm=%b fault=%b want 1010/0000/1",
                         i, dir_out, pwm_out, fault);
            end
        end
        tick();
        n_vec++;
        if (dir_out !== 4'b0000 || fault !== 1'b1) begin
            n_err++; $display("FAIL dead_end: dir=%b fault=%b want 0000/1", dir_out, fault);
        end
    endtask

    task automatic test_clear();
        wdt_trip = 1; clear = 1; tick();
        n_vec++;
        if (fault !== 1'b1) begin
            n_err++; $display("FAIL clear_blocked: fault=%b want 1", fault);
        end
        wdt_trip = 0; tick();
        clear = 0;
        n_vec++;
        if (fault !== 1'b0) begin
            n_err++; $display("FAIL clear_ok: fault=%b want 0", fault);
        end
        pwm_in = '0; arm = 1; tick();
        arm = 0; tick();
        wdt_trip = 1; tick();
        wdt_trip = 0;
        repeat (DEAD) tick();
        n_vec++;
        if (fault !== 1'b1 || trip_count !== 8'd2) begin
            n_err++; $display("FAIL retrip: fault=%b cnt=%0d want 1/2", fault, trip_count);
        end
        arm = 1; clear = 1; tick();
        arm = 0; clear = 0;
        tick(); tick();
        n_vec++;
        if (fault !== 1'b0 || running !== 1'b0) begin
            n_err++; $display("FAIL arm_clear: fault=%b run=%b want 0/0", fault, running);
        end
    endtask

    task automatic test_saturate();
        pwm_in = 4'b1111;
        for (int i = 0; i < 256; i++) begin
            arm = 1; tick();
            arm = 0; wdt_trip = 1; tick();
            wdt_trip = 0;
            repeat (DEAD) tick();
            clear = 1; tick();
            clear = 0;
        end
        n_vec++;
        if (trip_count !== 8'd255) begin
            n_err++; $display("FAIL saturate: cnt=%0d want 255", trip_count);
        end
    endtask

    task automatic test_reset_mid_hold();
        pwm_in = '0; dir_in = 4'b1111; arm = 1; tick();
        arm = 0; tick();
        wdt_trip = 1; tick();
        wdt_trip = 0; tick(); tick();
        n_vec++;
        if (fault !== 1'b1 || dir_out !== 4'b1111) begin
            n_err++; $display("FAIL pre_reset_hold: fault=%b dir=%b want 1/1111", fault, dir_out);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({pwm_out, dir_out, fault, running, trip_count} !== 18'h0) begin
            n_err++;
            $display("FAIL async_reset: pwm=%b dir=%b fault=%b run=%b cnt=%0d want all 0",
                     pwm_out, dir_out, fault, running, trip_count);
        end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            wdt_trip = ($urandom_range(0, 11) == 0);
            arm      = ($urandom_range(0, 5) == 0);
            clear    = ($urandom_range(0, 5) == 0);
            pwm_in   = 4'($urandom);
            dir_in   = 4'($urandom);
            tick();
            n_vec++;
            if (pwm_out !== m_pwm || dir_out !== m_dir || fault !== m_fault ||
                running !== m_run || trip_count !== 8'(m_cnt)) begin
                n_err++;
                $display("FAIL random[%0d]: pwm=%b dir=%b f=%b r=%b cnt=%0d want %b %b %b %b %0d",
                         i, pwm_out, dir_out, fault, running, trip_count,
                         m_pwm, m_dir, m_fault, m_run, m_cnt);
            end
        end
        wdt_trip = 0; arm = 0; clear = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_arm_zero();
        test_runt();
        test_trip();
        test_clear();
        test_saturate();
        test_reset_mid_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/servo_out_guard.md
Name: servo_out_guard

Overview:
- Output-safing stage directly downstream of the pluto_servo watchdog.
- Consumes the watchdog trip output and gates the PWM/direction outputs of all servo channels before they reach the pins.
- Holds outputs safe from reset until the host arms it.
- On a watchdog trip, forces PWM low, holds direction for a dead time, then forces direction low. It latches a sticky fault and counts trips for host readback.

Parameters:
- N, 4, number of servo channels.
- DEAD, 8, cycles direction is held after PWM is forced low on a trip (1..255).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- wdt_trip  input  1  watchdog timeout (1 = expired); level, synchronous to clk.
- arm  input  1  host arm strobe, one-cycle pulse.
- clear  input  1  host fault-clear strobe, one-cycle pulse.
- pwm_in  input  N  raw PWM from the PWM generators.
- dir_in  input  N  raw direction from the PWM generators.
- pwm_out  output  N  gated PWM to pins.
- dir_out  output  N  gated direction to pins.
- fault  output  1  sticky fault flag (1 in HOLD/TRIPPED).
- running  output  1  1 only in RUN.
- trip_count  output  8  saturating count of trips since reset.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=SAFE; all outputs 0; release mask 0; dead counter 0; trip_count 0.
- All outputs are registered. Pass-through latency is 1 cycle.
- States: SAFE, ARMING, RUN, HOLD, TRIPPED.
- SAFE:
  - pwm_out=0, dir_out=0, fault=0.
  - arm && !wdt_trip -> ARMING. arm while wdt_trip=1 is ignored.
  - wdt_trip alone keeps SAFE; trip_count is not incremented.
- ARMING:
  - Per channel i, release[i] sets on the first cycle pwm_in[i]==0 is sampled. This prevents a runt pulse.
  - pwm_out[i] = release[i] ? pwm_in[i] : 0. The release mask is updated and applied in the same clock edge, so the first passed pwm is the sample after the low.
  - dir_out = dir_in.
  - Next state is RUN once all release bits are set. If all pwm_in bits are low on the ARMING entry cycle, RUN is entered the next cycle.
  - wdt_trip -> HOLD, with priority over completing arming.
- RUN:
  - pwm_out=pwm_in, dir_out=dir_in (1-cycle delay), running=1.
  - wdt_trip -> HOLD.
- HOLD:
  - pwm_out=0 from the first cycle in HOLD.
  - dir_out frozen at its value on the last pre-HOLD cycle.
  - fault=1.
  - Dead counter loads DEAD on entry and decrements each cycle. At 0, go to TRIPPED. Total HOLD duration is exactly DEAD cycles.
  - wdt_trip and arm are ignored. clear is ignored (no early exit).
- TRIPPED:
  - pwm_out=0, dir_out=0, fault=1.
  - clear && !wdt_trip -> SAFE (fault=0 next cycle). clear while wdt_trip=1 is ignored.
  - arm is ignored.
- Entry into HOLD (from ARMING or RUN): trip_count += 1, saturating at 255 (no wrap).
- Release mask clears on every entry to SAFE, HOLD or TRIPPED.
- Simultaneous events:
  - arm+clear in TRIPPED: clear acts, arm is dropped. A new arm is required from SAFE.
  - arm+wdt_trip in SAFE: stays SAFE.
  - wdt_trip in the same cycle ARMING completes: HOLD wins.
- A reset asserted mid-HOLD aborts the dead time immediately; outputs go 0 asynchronously.

Test Plan:
- Reset, pulse arm with wdt_trip=0, pwm_in=4'b0000 -> ARMING then RUN 1 cycle later; running=1; pwm_out follows pwm_in with 1-cycle delay.
- Arm with pwm_in=4'b0101 held, then drop bit0 low for 1 cycle -> pwm_out[0] passes only after that low; bit2 stays 0 until pwm_in[2] is seen low; RUN entered only after both.
- In RUN with dir_in=4'b1010, assert wdt_trip -> pwm_out=0 the next cycle; dir_out stays 1010 for exactly 8 cycles then 0000; fault=1; trip_count=1.
- In TRIPPED, pulse clear while wdt_trip=1 -> stays TRIPPED. Deassert wdt_trip, pulse clear -> SAFE, fault=0. Pulse arm+clear together in TRIPPED -> SAFE, not ARMING.
- Trip 256 times -> trip_count saturates at 255. Assert rst_n=0 mid-HOLD -> all outputs 0 without a clock edge, trip_count=0.
